dot_product_seq_ctrl: RTL and testbench

Sequencer and accumulator wrapped around the combinational DEPTH-lane dot_product_parallel datapath. It accepts a vector as a stream of DEPTH-element chunks over a valid/ready input handshake and registers each chunk's 17-bit partial sum. It accumulates the chunks of one vector and returns one saturated signed result per vector over a valid/ready output handshake. It sits between the layer memory fetch logic and the result writeback in the accelerator.

---
 rtl/mannix_dp_pkg.sv | 42 ++++
 rtl/dot_product_parallel.sv | 32 +++
 rtl/dot_product_seq_ctrl_acc_sat.sv | 58 +++++
 rtl/dot_product_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_dot_product_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mannix_dp_pkg.sv
// Shared types and helpers for the dot-product sequencer.
// FSM states, datapath widths, output saturation function.
package mannix_dp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    OUT
  } dp_state_e;

  localparam int DP_OP_W  = 8;
  localparam int DP_SUM_W = 17;
  localparam int DP_SAT_W = 32;

  typedef struct packed {
    logic                       sat;
    logic signed [DP_SAT_W-1:0] val;
  } dp_sat_t;

  // Clamp a signed value into a w-bit signed range.
  function automatic dp_sat_t sat_to_w(
    input logic signed [DP_SAT_W-1:0] v,
    input int                         w
  );
    dp_sat_t                    r;
    logic signed [DP_SAT_W-1:0] hi;
    logic signed [DP_SAT_W-1:0] lo;
    hi = DP_SAT_W'((longint'(1) <<< (w - 1))
                   - longint'(1));
    lo = -hi - 1;
    r.sat = (v > hi) || (v < lo);
    if (v > hi)
      r.val = hi;
    else if (v < lo)
      r.val = lo;
    else
      r.val = v;
    return r;
  endfunction

endpackage

// File: rtl/dot_product_parallel.sv
// Combinational DEPTH-lane signed 8x8 dot product.
// Ports: i_a/i_b packed lanes, o_sum 17-bit chunk sum.
module dot_product_parallel
  import mannix_dp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DP_OP_W*DEPTH-1:0]  i_a,
  input  logic [DP_OP_W*DEPTH-1:0]  i_b,
  output logic signed [DP_SUM_W-1:0] o_sum
);

  localparam int PW = 2 * DP_OP_W;

  logic signed [PW-1:0]       w_prod;
  logic signed [DP_SUM_W-1:0] w_sum;

  always_comb begin
    w_prod = '0;
    w_sum  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_prod = $signed(i_a[i*DP_OP_W +: DP_OP_W])
             * $signed(i_b[i*DP_OP_W +: DP_OP_W]);
      w_sum  = w_sum
             + {{(DP_SUM_W-PW){w_prod[PW-1]}},
                w_prod};
    end
  end

  assign o_sum = w_sum;

endmodule

// File: rtl/dot_product_seq_ctrl_acc_sat.sv
// Vector accumulator with registered saturated result.
// Ports: clr/add/load controls, i_part chunk sum, o_res/o_sat.
module dp_acc_sat
  import mannix_dp_pkg::*;
#(
  parameter int ACC_W = 22,
  parameter int OUT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clr,
  input  logic                       i_add,
  input  logic                       i_load,
  input  logic signed [DP_SUM_W-1:0] i_part,
  output logic [OUT_W-1:0]           o_res,
  output logic                       o_sat
);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic [OUT_W-1:0]        r_res;
  logic                    r_sat;
  dp_sat_t                 w_s;
  logic                    w_unused_hi;

  always_comb begin
    w_acc_nxt = r_acc;
    if (i_clr)
      w_acc_nxt = '0;
    else if (i_add)
      w_acc_nxt = r_acc
                + {{(ACC_W-DP_SUM_W){i_part[DP_SUM_W-1]}},
                   i_part};
  end

  // Result is captured from the next accumulator value so the
  // last chunk added on the way into OUT is already included.
  assign w_s = sat_to_w(DP_SAT_W'(w_acc_nxt), OUT_W);
  assign w_unused_hi = ^w_s.val[DP_SAT_W-1:OUT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_res <= '0;
      r_sat <= 1'b0;
    end else begin
      r_acc <= w_acc_nxt;
      if (i_load) begin
        r_res <= w_s.val[OUT_W-1:0];
        r_sat <= w_s.sat;
      end
    end
  end

  assign o_res = r_res;
  assign o_sat = r_sat;

endmodule

// File: rtl/dot_product_seq_ctrl.sv
// Chunked dot-product sequencer: streams DEPTH-lane chunks,
// accumulates per vector, returns one saturated result.
// Ports: start/cfg_len/busy control, in_* chunk stream,
// out_* result stream.
module dot_product_seq_ctrl
  import mannix_dp_pkg::*;
#(
  parameter  int DEPTH      = 4,
  parameter  int MAX_CHUNKS = 16,
  parameter  int OUT_W      = 16,
  localparam int CNT_W      = $clog2(MAX_CHUNKS + 1),
  localparam int ACC_W      = DP_SUM_W + CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CNT_W-1:0]         cfg_len,
  output logic                     busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DP_OP_W*DEPTH-1:0] in_a,
  input  logic [DP_OP_W*DEPTH-1:0] in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_res,
  output logic                     out_sat
);

  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_CHUNKS);

  dp_state_e                 r_state;
  dp_state_e                 w_next;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          r_len;
  logic [CNT_W-1:0]          w_len;
  logic signed [DP_SUM_W-1:0] r_p;
  logic                      r_p_vld;
  logic signed [DP_SUM_W-1:0] w_sum;
  logic                      w_start_acc;
  logic                      w_in_hs;
  logic                      w_last;
  logic                      w_load;

  dot_product_parallel #(
    .DEPTH (DEPTH)
  ) u_dp (
    .i_a   (in_a),
    .i_b   (in_b),
    .o_sum (w_sum)
  );

  assign w_len  = (cfg_len > MAXC) ? MAXC : cfg_len;
  assign w_last = (r_cnt + 1'b1) == r_len;

  always_comb begin
    w_next      = r_state;
    w_start_acc = 1'b0;
    w_in_hs     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_next = (w_len == '0) ? OUT : RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          w_in_hs = 1'b1;
          if (w_last)
            w_next = FLUSH;
        end
      end
      FLUSH: w_next = OUT;
      OUT: begin
        if (out_ready)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    w_load = (w_next == OUT) && (r_state != OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_len   <= '0;
      r_p     <= '0;
      r_p_vld <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_len <= w_len;
        r_cnt <= '0;
      end else if (w_in_hs) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_p_vld <= w_in_hs;
      if (w_in_hs)
        r_p <= w_sum;
    end
  end

  dp_acc_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_start_acc),
    .i_add  (r_p_vld),
    .i_load (w_load),
    .i_part (r_p),
    .o_res  (out_res),
    .o_sat  (out_sat)
  );

  assign busy      = (r_state != IDLE);
  assign in_ready  = (r_state == RUN);
  assign out_valid = (r_state == OUT);

endmodule

// File: tb/tb_dot_product_seq_ctrl.sv
// Scoreboard bench for dot_product_seq_ctrl.
// Expected results queued at vector start, checked on output.
module tb_dot_product_seq_ctrl;

  localparam int DEPTH = 4;
  localparam int CNT_W = 5;
  localparam int VW    = 8 * DEPTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] cfg_len = '0;
  logic             busy;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [VW-1:0]    in_a = '0;
  logic [VW-1:0]    in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [15:0]      out_res;
  logic             out_sat;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_res[$];
  int exp_sat[$];

  dot_product_seq_ctrl #(
    .DEPTH      (DEPTH),
    .MAX_CHUNKS (16),
    .OUT_W      (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_len   (cfg_len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_res.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        check("out_res", int'($signed(out_res)),
              exp_res.pop_front());
        check("out_sat", int'(out_sat),
              exp_sat.pop_front());
      end
    end
  end

  function automatic logic [VW-1:0] all_lanes(input int v);
    logic [VW-1:0] r;
    for (int i = 0; i < DEPTH; i++)
      r[i*8 +: 8] = v[7:0];
    return r;
  endfunction

  function automatic logic [VW-1:0] lane0(input int v);
    logic [VW-1:0] r;
    r = '0;
    r[7:0] = v[7:0];
    return r;
  endfunction

  task automatic expect_out(input int res, input int sat);
    exp_res.push_back(res);
    exp_sat.push_back(sat);
  endtask

  task automatic do_start(input int len);
    start   = 1'b1;
    cfg_len = len[CNT_W-1:0];
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [VW-1:0] a,
                      input logic [VW-1:0] b);
    int n;
    n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50)
      check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, int'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_res", int'(out_res), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // two chunks of 8 -> 16, latency two cycles
    expect_out(16, 0);
    do_start(2);
    send(all_lanes(1), all_lanes(2));
    send(all_lanes(1), all_lanes(2));
    @(negedge clk);
    check("lat_t1_low", int'(out_valid), 0);
    @(negedge clk);
    check("lat_t2_high", int'(out_valid), 1);
    wait_idle("t1_idle");

    // positive and negative saturation
    expect_out(32767, 1);
    do_start(1);
    send(all_lanes(127), all_lanes(127));
    wait_idle("t2a_idle");
    expect_out(-32768, 1);
    do_start(1);
    send(all_lanes(-128), all_lanes(127));
    wait_idle("t2b_idle");

    // gaps on input, backpressure on output
    out_ready = 1'b0;
    expect_out(13, 0);
    do_start(3);
    send(lane0(10), lane0(1));
    repeat (3) @(posedge clk);
    #1;
    send(lane0(-4), lane0(1));
    repeat (3) @(posedge clk);
    #1;
    send(lane0(7), lane0(1));
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_valid", int'(out_valid), 1);
      check("t3_hold_res", int'($signed(out_res)), 13);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t3_idle_busy", int'(busy), 0);
    check("t3_idle_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;

    // zero-length vector
    expect_out(0, 0);
    do_start(0);
    @(negedge clk);
    check("t4_valid", int'(out_valid), 1);
    check("t4_in_ready", int'(in_ready), 0);
    wait_idle("t4_idle");

    // start during RUN is ignored
    expect_out(7, 0);
    do_start(2);
    send(lane0(3), lane0(1));
    start   = 1'b1;
    cfg_len = 5'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("t5_still_run", int'(in_ready), 1);
    @(posedge clk);
    #1;
    send(lane0(4), lane0(1));
    wait_idle("t5_idle");

    // reset mid-vector discards partial work
    do_start(4);
    send(lane0(9), lane0(1));
    rst_n = 1'b0;
    #2;
    check("t6_busy", int'(busy), 0);
    check("t6_in_ready", int'(in_ready), 0);
    check("t6_out_valid", int'(out_valid), 0);
    check("t6_out_res", int'(out_res), 0);
    check("t6_out_sat", int'(out_sat), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_out(5, 0);
    do_start(1);
    send(lane0(5), lane0(1));
    wait_idle("t6_idle");

    check("queue_empty", exp_res.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
